// File: rtl/teller_dispatcher.sv
// Teller-side dispatcher for the bank queue: issues tickets on entry,
// calls tickets in order on teller request, and flags customers who do
// not reach the counter in time.
module teller_dispatcher #(
  parameter int CAP      = 7,  // max waiting customers (1..7)
  parameter int TIMEOUT  = 8,  // CALL cycles allowed before no-show (2..15)
  parameter int SVC_TIME = 3,  // service time units per customer
  parameter int TCOUT    = 1   // active tellers (>=1)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_join,
  input  logic       i_next_req,
  input  logic       i_arrived,
  output logic       o_call_valid,
  output logic [2:0] o_call_ticket,
  output logic       o_busy,
  output logic       o_noshow,
  output logic [2:0] o_qcount,
  output logic       o_full,
  output logic       o_empty,
  output logic [4:0] o_wtime
);

  localparam logic [2:0] CAP_Q = 3'(CAP);
  localparam logic [3:0] T_LAST = 4'(TIMEOUT - 1);

  // Wait estimate per possible queue depth, resolved at elaboration so the
  // runtime path is a plain 8-entry lookup on the registered count.
  function automatic logic [7:0][4:0] build_wtab();
    logic [7:0][4:0] t;
    int w;
    for (int q = 0; q < 8; q++) begin
      w = SVC_TIME * ((q + TCOUT - 1) / TCOUT);
      t[q] = (w > 31) ? 5'd31 : 5'(w);
    end
    return t;
  endfunction

  localparam logic [7:0][4:0] WTAB = build_wtab();

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALL  = 2'd1,
    S_SERVE = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_head, r_tail, r_qcount, r_ticket;
  logic [3:0] r_timer;
  logic       r_noshow;
  logic       w_dispatch, w_timeout, w_join_ok, w_empty, w_full;

  assign w_empty   = (r_qcount == 3'd0);
  assign w_full    = (r_qcount == CAP_Q);
  // A dispatch frees a slot in the same cycle, so a join is never lost then.
  assign w_join_ok = i_join && (!w_full || w_dispatch);

  // Next-state decode; dispatch marks every entry into CALL.
  always_comb begin
    w_state_nxt = r_state;
    w_dispatch  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_next_req && !w_empty) begin
          w_state_nxt = S_CALL;
          w_dispatch  = 1'b1;
        end
      end
      S_CALL: begin
        if (i_arrived) begin
          w_state_nxt = S_SERVE;
        end else if (r_timer == T_LAST) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_SERVE: begin
        if (i_next_req) begin
          if (!w_empty) begin
            w_state_nxt = S_CALL;
            w_dispatch  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Ticket pointers, waiting count, call timer and no-show pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head   <= 3'd0;
      r_tail   <= 3'd0;
      r_qcount <= 3'd0;
      r_ticket <= 3'd0;
      r_timer  <= 4'd0;
      r_noshow <= 1'b0;
    end else begin
      r_noshow <= w_timeout;
      if (w_join_ok) r_tail <= r_tail + 3'd1;
      if (w_dispatch) begin
        r_ticket <= r_head;
        r_head   <= r_head + 3'd1;
        r_timer  <= 4'd0;
      end else if (r_state == S_CALL && !i_arrived && !w_timeout) begin
        r_timer <= r_timer + 4'd1;
      end
      case ({w_join_ok, w_dispatch})
        2'b10:   r_qcount <= r_qcount + 3'd1;
        2'b01:   r_qcount <= r_qcount - 3'd1;
        default: r_qcount <= r_qcount;
      endcase
    end
  end

  assign o_call_valid  = (r_state == S_CALL);
  assign o_busy        = (r_state == S_SERVE);
  assign o_call_ticket = r_ticket;
  assign o_noshow      = r_noshow;
  assign o_qcount      = r_qcount;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_wtime       = WTAB[r_qcount];

endmodule

// File: tb/tb_teller_dispatcher.sv
// Bench for teller_dispatcher: directed scenarios plus a randomized run,
// checked against a ticket-queue model of the dispatcher.
module tb_teller_dispatcher;

  localparam int CAP      = 7;
  localparam int TIMEOUT  = 8;
  localparam int SVC_TIME = 3;
  localparam int TCOUT    = 1;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_join = 1'b0, i_next_req = 1'b0, i_arrived = 1'b0;
  logic       o_call_valid, o_busy, o_noshow, o_full, o_empty;
  logic [2:0] o_call_ticket, o_qcount;
  logic [4:0] o_wtime;

  int n_tests = 0;
  int n_fail  = 0;

  teller_dispatcher #(.CAP(CAP), .TIMEOUT(TIMEOUT), .SVC_TIME(SVC_TIME), .TCOUT(TCOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_join(i_join), .i_next_req(i_next_req),
    .i_arrived(i_arrived), .o_call_valid(o_call_valid), .o_call_ticket(o_call_ticket),
    .o_busy(o_busy), .o_noshow(o_noshow), .o_qcount(o_qcount), .o_full(o_full),
    .o_empty(o_empty), .o_wtime(o_wtime)
  );

  always #5 i_clk = ~i_clk;

  // Model: waiting tickets in a queue, mode 0=idle 1=calling 2=serving.
  int m_q[$];
  int m_tail, m_mode, m_ticket, m_elapsed;
  bit m_noshow;

  task automatic model_reset();
    m_q.delete();
    m_tail = 0; m_mode = 0; m_ticket = 0; m_elapsed = 0; m_noshow = 0;
  endtask

  task automatic model_step(input bit j, input bit n, input bit a);
    bit disp = 0, ns = 0, acc;
    case (m_mode)
      0: if (n && m_q.size() > 0) disp = 1;
      1: begin
        if (a) m_mode = 2;
        else if (m_elapsed == TIMEOUT - 1) begin m_mode = 0; ns = 1; end
        else m_elapsed++;
      end
      default: if (n) begin
        if (m_q.size() > 0) disp = 1;
        else m_mode = 0;
      end
    endcase
    acc = j && (m_q.size() < CAP || disp);
    if (disp) begin m_ticket = m_q.pop_front(); m_mode = 1; m_elapsed = 0; end
    if (acc) begin m_q.push_back(m_tail); m_tail = (m_tail + 1) % 8; end
    m_noshow = ns;
  endtask

  function automatic int exp_wtime(input int q);
    int w = SVC_TIME * ((q + TCOUT - 1) / TCOUT);
    return (w > 31) ? 31 : w;
  endfunction

  // Drive one cycle of input pulses, advance the model, sample after the edge.
  task automatic cyc(input bit j, input bit n, input bit a);
    i_join = j; i_next_req = n; i_arrived = a;
    @(posedge i_clk);
    model_step(j, n, a);
    #1;
    i_join = 0; i_next_req = 0; i_arrived = 0;
  endtask

  task automatic do_reset();
    i_join = 0; i_next_req = 0; i_arrived = 0;
    i_rst_n = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0, 0, 0);
    n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", o_empty); end
    n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", o_full); end
    n_tests++; if (o_qcount !== 3'd0) begin n_fail++; $display("FAIL reset_qcount got %0d want 0", o_qcount); end
    n_tests++; if (o_wtime !== 5'd0) begin n_fail++; $display("FAIL reset_wtime got %0d want 0", o_wtime); end
    n_tests++; if ({o_call_valid, o_busy, o_noshow} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b want 000", {o_call_valid, o_busy, o_noshow}); end
    n_tests++; if (o_call_ticket !== 3'd0) begin n_fail++; $display("FAIL reset_ticket got %0d want 0", o_call_ticket); end
  endtask

  task automatic test_dispatch();
    do_reset();
    repeat (3) cyc(1, 0, 0);
    cyc(0, 1, 0);
    n_tests++; if (o_call_valid !== 1'b1) begin n_fail++; $display("FAIL disp_valid got %b want 1", o_call_valid); end
    n_tests++; if (o_call_ticket !== 3'd0) begin n_fail++; $display("FAIL disp_ticket got %0d want 0", o_call_ticket); end
    n_tests++; if (o_qcount !== 3'd2) begin n_fail++; $display("FAIL disp_qcount got %0d want 2", o_qcount); end
    n_tests++; if (o_wtime !== 5'd6) begin n_fail++; $display("FAIL disp_wtime got %0d want 6", o_wtime); end
    cyc(0, 0, 1);
    n_tests++; if ({o_busy, o_call_valid} !== 2'b10) begin n_fail++; $display("FAIL serve_flags got %b want 10", {o_busy, o_call_valid}); end
    cyc(0, 1, 0);
    n_tests++; if (o_call_ticket !== 3'd1) begin n_fail++; $display("FAIL next_ticket got %0d want 1", o_call_ticket); end
    n_tests++; if (o_qcount !== 3'd1) begin n_fail++; $display("FAIL next_qcount got %0d want 1", o_qcount); end
  endtask

  task automatic test_noshow();
    int cnt = 0;
    do_reset();
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    while (o_call_valid === 1'b1 && cnt < 20) begin
      cnt++;
      if (o_noshow !== 1'b0) begin n_tests++; n_fail++; $display("FAIL noshow_early at %0d got 1 want 0", cnt); end
      cyc(0, 0, 0);
    end
    n_tests++; if (cnt != TIMEOUT) begin n_fail++; $display("FAIL call_len got %0d want %0d", cnt, TIMEOUT); end
    n_tests++; if (o_noshow !== 1'b1) begin n_fail++; $display("FAIL noshow_pulse got %b want 1", o_noshow); end
    n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL noshow_empty got %b want 1", o_empty); end
    cyc(0, 0, 1);
    n_tests++; if ({o_noshow, o_busy, o_call_valid} !== 3'b000) begin n_fail++; $display("FAIL late_arrive got %b want 000", {o_noshow, o_busy, o_call_valid}); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    repeat (8) cyc(1, 0, 0);
    n_tests++; if (o_qcount !== 3'd7) begin n_fail++; $display("FAIL full_qcount got %0d want 7", o_qcount); end
    n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b want 1", o_full); end
    n_tests++; if (o_wtime !== 5'd21) begin n_fail++; $display("FAIL full_wtime got %0d want 21", o_wtime); end
    for (int k = 0; k < 9; k++) begin
      cyc(1, 1, 0);
      n_tests++; if (o_call_ticket !== 3'(k % 8)) begin n_fail++; $display("FAIL wrap_ticket[%0d] got %0d want %0d", k, o_call_ticket, k % 8); end
      n_tests++; if (o_qcount !== 3'd7 || o_full !== 1'b1) begin n_fail++; $display("FAIL wrap_full[%0d] got q=%0d f=%b want q=7 f=1", k, o_qcount, o_full); end
      cyc(0, 0, 1);
      n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy[%0d] got %b want 1", k, o_busy); end
    end
  endtask

  task automatic test_join_dispatch();
    do_reset();
    repeat (2) cyc(1, 0, 0);
    cyc(1, 1, 0);
    n_tests++; if (o_qcount !== 3'd2) begin n_fail++; $display("FAIL jd_qcount got %0d want 2", o_qcount); end
    n_tests++; if (o_call_ticket !== 3'd0 || o_call_valid !== 1'b1) begin n_fail++; $display("FAIL jd_call got t=%0d v=%b want t=0 v=1", o_call_ticket, o_call_valid); end
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    n_tests++; if (o_call_ticket !== 3'd2 || o_empty !== 1'b1) begin n_fail++; $display("FAIL jd_tail got t=%0d e=%b want t=2 e=1", o_call_ticket, o_empty); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    #2;
    i_rst_n = 0;
    #1;
    n_tests++; if ({o_call_valid, o_busy, o_noshow} !== 3'b000) begin n_fail++; $display("FAIL async_ctrl got %b want 000", {o_call_valid, o_busy, o_noshow}); end
    n_tests++; if (o_qcount !== 3'd0 || o_empty !== 1'b1 || o_call_ticket !== 3'd0) begin n_fail++; $display("FAIL async_state got q=%0d e=%b t=%0d want q=0 e=1 t=0", o_qcount, o_empty, o_call_ticket); end
    @(posedge i_clk); #1;
    i_rst_n = 1;
    model_reset();
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    repeat (TIMEOUT - 1) cyc(0, 0, 0);
    n_tests++; if (o_call_valid !== 1'b1) begin n_fail++; $display("FAIL last_call got %b want 1", o_call_valid); end
    cyc(0, 0, 1);
    n_tests++; if ({o_busy, o_noshow} !== 2'b10) begin n_fail++; $display("FAIL edge_arrive got %b want 10", {o_busy, o_noshow}); end
    cyc(0, 0, 0);
    n_tests++; if ({o_busy, o_noshow} !== 2'b10) begin n_fail++; $display("FAIL edge_after got %b want 10", {o_busy, o_noshow}); end
  endtask

  task automatic test_random();
    bit j, n, a;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      j = ($urandom_range(0, 99) < 45);
      n = ($urandom_range(0, 99) < 20);
      a = ($urandom_range(0, 99) < 12);
      cyc(j, n, a);
      n_tests++; if (o_call_valid !== (m_mode == 1)) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b want %b", c, o_call_valid, m_mode == 1); end
      n_tests++; if (o_busy !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b want %b", c, o_busy, m_mode == 2); end
      n_tests++; if (o_noshow !== m_noshow) begin n_fail++; $display("FAIL rnd_noshow c=%0d got %b want %b", c, o_noshow, m_noshow); end
      n_tests++; if (o_call_ticket !== 3'(m_ticket)) begin n_fail++; $display("FAIL rnd_ticket c=%0d got %0d want %0d", c, o_call_ticket, m_ticket); end
      n_tests++; if (o_qcount !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_qcount c=%0d got %0d want %0d", c, o_qcount, m_q.size()); end
      n_tests++; if (o_full !== (m_q.size() == CAP) || o_empty !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_flags c=%0d got f=%b e=%b size=%0d", c, o_full, o_empty, m_q.size()); end
      n_tests++; if (o_wtime !== 5'(exp_wtime(m_q.size()))) begin n_fail++; $display("FAIL rnd_wtime c=%0d got %0d want %0d", c, o_wtime, exp_wtime(m_q.size())); end
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_noshow();
    test_full_wrap();
    test_join_dispatch();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
